// File: rtl/onehot_dispatch6.sv
// onehot_dispatch6: routes a data item to one of six single-entry output slots by one-hot select
//   in_data/in_sel/in_valid/in_ready : producer side; malformed selects are always consumed and dropped
//   out_data/out_valid/out_ready     : six independent slot handshakes, slot k at [k*BITS +: BITS]
//   err/drop_cnt/err_clr             : sticky drop flag and saturating drop counter, synchronous clear
module onehot_dispatch6 #(
    parameter int BITS  = 3,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BITS-1:0]     in_data,
    input  logic [5:0]          in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [6*BITS-1:0]   out_data,
    output logic [5:0]          out_valid,
    input  logic [5:0]          out_ready,
    output logic                err,
    output logic [CNT_W-1:0]    drop_cnt,
    input  logic                err_clr
);
    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;
    logic [5:0]        valid_q, valid_d, wr;
    logic [6*BITS-1:0] data_q, data_d;
    logic              err_q, err_d, onehot, drop;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // x & (x-1) clears the lowest set bit, so it is zero only for a single set bit
    assign onehot   = (in_sel != 6'd0) && ((in_sel & (in_sel - 6'd1)) == 6'd0);
    assign in_ready = onehot ? |(in_sel & (~valid_q | out_ready)) : 1'b1;
    assign wr       = (in_valid && in_ready && onehot) ? in_sel : 6'd0;
    assign drop     = in_valid && !onehot;
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < 6; k++) begin
            valid_d[k] = (wr[k] || (valid_q[k] == FULL && !out_ready[k])) ? FULL : EMPTY;
            data_d[k*BITS +: BITS] = wr[k] ? in_data : data_q[k*BITS +: BITS];
        end
    end
    // a drop in the same cycle as a clear wins: the counter restarts at one
    always_comb begin
        err_d = drop ? 1'b1 : (err_clr ? 1'b0 : err_q);
        cnt_d = drop ? (err_clr ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1))
                     : (err_clr ? '0 : cnt_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err       = err_q;
    assign drop_cnt  = cnt_q;
endmodule
